// File: rtl/aux_result_wr_if.sv
// AXI4 write-channel (AW/W/B) and AXI4-Stream result bundle used by aux_result_wr.
interface aux_result_wr_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 128
);
    logic                          m_axi_awready;
    logic                          m_axi_awvalid;
    logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr;
    logic [7:0]                    m_axi_awlen;
    logic                          m_axi_wready;
    logic                          m_axi_wvalid;
    logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb;
    logic                          m_axi_wlast;
    logic                          m_axi_bready;
    logic                          m_axi_bvalid;
    logic [1:0]                    m_axi_bresp;
    logic                          s_res_tready;
    logic                          s_res_tvalid;
    logic [AXI_DATA_WIDTH-1:0]     s_res_tdata;

    modport master (
        input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
               s_res_tvalid, s_res_tdata,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
               m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
               m_axi_bready, s_res_tready
    );

    modport slave (
        output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
               s_res_tvalid, s_res_tdata,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
               m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
               m_axi_bready, s_res_tready
    );
endinterface

// File: rtl/aux_result_wr.sv
// Buffers a burst of result-stream beats and writes them out as one AXI4 INCR burst.
module aux_result_wr #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned RES_FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] num_beats,
    input  logic [63:0] base_addr,
    output logic [31:0] status,
    aux_result_wr_if.master bus
);
    localparam int unsigned PTR_W = $clog2(RES_FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t                    state;
    logic                      start_q;
    logic                      start_armed;
    logic                      start_p;
    logic [7:0]                n_q;
    logic [8:0]                n_total;
    logic [8:0]                in_cnt;
    logic [8:0]                w_cnt;
    logic [AXI_DATA_WIDTH-1:0] mem [RES_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W:0]            count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      aw_hs;
    logic                      b_hs;
    logic [7:0]                aw_stat;
    logic [7:0]                w_stat;
    logic [7:0]                s_stat;
    logic [7:0]                b_stat;
    logic                      unused_ok;

    assign unused_ok = &{1'b0, num_beats[31:8]};

    // A start already high at reset release must first be seen low (armed) before it counts.
    assign start_p    = (state == S_IDLE) && ap_start && !start_q && start_armed;
    assign n_total    = {(n_q == 8'd0), n_q};
    assign fifo_full  = count[PTR_W];
    assign fifo_empty = (count == '0);

    assign bus.s_res_tready = (state != S_IDLE) && (state != S_DONE) && !fifo_full
                              && (in_cnt < n_total);
    assign bus.m_axi_wvalid = (state == S_DATA) && !fifo_empty;
    assign bus.m_axi_wdata  = mem[rd_ptr];
    assign bus.m_axi_wstrb  = '1;
    assign bus.m_axi_wlast  = (w_cnt == (n_total - 9'd1));

    assign push  = bus.s_res_tvalid && bus.s_res_tready;
    assign pop   = bus.m_axi_wvalid && bus.m_axi_wready;
    assign aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
    assign b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;

    assign ap_ready = ap_done;
    assign ap_idle  = (state == S_IDLE) && !ap_start;
    assign status   = {aw_stat, w_stat, s_stat, b_stat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_q <= ap_start;
            if (!ap_start) start_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            bus.m_axi_awvalid <= 1'b0;
            bus.m_axi_awaddr  <= '0;
            bus.m_axi_awlen   <= '0;
            bus.m_axi_bready  <= 1'b0;
            ap_done           <= 1'b0;
            n_q               <= '0;
            in_cnt            <= '0;
            w_cnt             <= '0;
        end else begin
            ap_done <= 1'b0;
            if (push) in_cnt <= in_cnt + 9'd1;
            if (pop)  w_cnt  <= w_cnt + 9'd1;
            unique case (state)
                S_IDLE: if (start_p) begin
                    state             <= S_ADDR;
                    bus.m_axi_awvalid <= 1'b1;
                    bus.m_axi_awaddr  <= base_addr[AXI_ADDR_WIDTH-1:0];
                    bus.m_axi_awlen   <= num_beats[7:0] - 8'd1;
                    n_q               <= num_beats[7:0];
                    in_cnt            <= '0;
                    w_cnt             <= '0;
                end
                S_ADDR: if (aw_hs) begin
                    state             <= S_DATA;
                    bus.m_axi_awvalid <= 1'b0;
                    bus.m_axi_awaddr  <= '0;
                    bus.m_axi_awlen   <= '0;
                end
                S_DATA: if (pop && bus.m_axi_wlast) begin
                    state            <= S_RESP;
                    bus.m_axi_bready <= 1'b1;
                end
                S_RESP: if (b_hs) begin
                    state            <= S_DONE;
                    bus.m_axi_bready <= 1'b0;
                    ap_done          <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.s_res_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_stat <= '0;
            w_stat  <= '0;
            s_stat  <= '0;
            b_stat  <= '0;
        end else begin
            if (aw_hs) aw_stat <= aw_stat + 8'd1;
            if (pop)   w_stat  <= w_stat + 8'd1;
            if (push)  s_stat  <= s_stat + 8'd1;
            if (b_hs && (bus.m_axi_bresp == 2'b00)) b_stat <= b_stat + 8'd1;
        end
    end
endmodule

// File: tb/tb_aux_result_wr.sv
// Randomised scoreboard bench for aux_result_wr: expected AW/W traffic queued at issue, checked by a monitor.
module tb_aux_result_wr;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 128;

    typedef struct { logic [63:0] addr; logic [7:0] len; } awexp_t;
    typedef struct { logic [127:0] data; logic last; } wexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] num_beats = '0;
    logic [63:0] base_addr = '0;
    logic [31:0] status;

    aux_result_wr_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

    aux_result_wr #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .RES_FIFO_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .num_beats(num_beats),
        .base_addr(base_addr), .status(status), .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0, n_total = 0;
    awexp_t      aw_q[$];
    wexp_t       w_q[$];
    int unsigned aw_delay = 0, wready_mode = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    int unsigned m_aw = 0, m_w = 0, m_s = 0, m_b = 0;
    int unsigned w_in_burst = 0, s_in_burst = 0, exp_n = 0, done_pulses = 0;
    bit          aw_seen = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // AW slave: waits aw_delay cycles of awvalid before accepting
    initial begin
        int unsigned aw_wait = 0;
        bus.m_axi_awready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.m_axi_awvalid && !bus.m_axi_awready) begin
                if (aw_wait >= aw_delay) begin bus.m_axi_awready = 1'b1; aw_wait = 0; end
                else aw_wait++;
            end else bus.m_axi_awready = 1'b0;
        end
    end

    initial begin
        bus.m_axi_wready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (wready_mode)
                0:       bus.m_axi_wready = 1'b1;
                1:       bus.m_axi_wready = ~bus.m_axi_wready;
                default: bus.m_axi_wready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (bus.m_axi_bready && !bus.m_axi_bvalid) begin
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp  = bresp_cfg;
            end else if (!bus.m_axi_bready) bus.m_axi_bvalid = 1'b0;
        end
    end

    // Monitor: compares every handshake seen against the queued expectations
    initial begin
        awexp_t ae;
        wexp_t  we;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                    if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
                    else begin
                        ae = aw_q.pop_front();
                        check("awaddr", bus.m_axi_awaddr, ae.addr);
                        check("awlen", bus.m_axi_awlen, ae.len);
                    end
                    aw_seen = 1'b1;
                end
                if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                    check("w_after_aw", aw_seen, 1);
                    if (w_q.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        we = w_q.pop_front();
                        check("wdata", bus.m_axi_wdata, we.data);
                        check("wlast", bus.m_axi_wlast, we.last);
                        check("wstrb", bus.m_axi_wstrb, 16'hFFFF);
                    end
                    w_in_burst++;
                end
                if (bus.s_res_tvalid && bus.s_res_tready) begin
                    s_in_burst++;
                    check("s_accept_limit", s_in_burst <= exp_n, 1);
                end
                if (ap_done || ap_ready) begin
                    check("ap_ready_eq_done", ap_ready, ap_done);
                    if (ap_done) done_pulses++;
                    aw_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [127:0] d, output bit ok);
        int unsigned t = 0;
        ok = 1'b1;
        bus.s_res_tvalid = 1'b1;
        bus.s_res_tdata  = d;
        do begin @(negedge clk); t++; end while (!bus.s_res_tready && t < 500);
        if (!bus.s_res_tready) begin check("tready_timeout", 0, 1); ok = 1'b0; end
        @(posedge clk); #1;
        bus.s_res_tvalid = 1'b0;
    endtask

    task automatic run_burst(input logic [63:0] addr, input logic [31:0] nb, input bit fixed_data,
                             input bit hold_start, input bit mid_pulse, input bit extra_valid);
        int unsigned n = (nb[7:0] == 8'd0) ? 256 : int'(nb[7:0]);
        int unsigned t, done0;
        logic [127:0] d;
        bit ok;
        aw_q.push_back('{addr, 8'(n - 1)});
        exp_n = n; w_in_burst = 0; s_in_burst = 0; done0 = done_pulses;
        base_addr = addr; num_beats = nb;
        check("idle_before_start", ap_idle, 1);
        ap_start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) ap_start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            d = fixed_data ? 128'(10 + i) : {$urandom, $urandom, $urandom, $urandom};
            w_q.push_back('{d, (i == int'(n) - 1)});
            send_beat(d, ok);
            if (!ok) break;
            if (mid_pulse && i == 1) begin
                ap_start = 1'b1; @(posedge clk); #1; ap_start = 1'b0;
            end
        end
        if (extra_valid) begin
            bus.s_res_tvalid = 1'b1;
            bus.s_res_tdata  = '1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("tready_drop", bus.s_res_tready, 0);
            repeat (8) @(posedge clk);
            #1 bus.s_res_tvalid = 1'b0;
        end
        t = 0;
        while (done_pulses == done0 && t < 5000) begin @(negedge clk); t++; end
        check("done_seen", done_pulses != done0, 1);
        repeat (4) @(negedge clk);
        check("done_once", done_pulses - done0, 1);
        check("w_beats", w_in_burst, n);
        check("s_beats", s_in_burst, n);
        m_aw++; m_w += n; m_s += n;
        if (bresp_cfg == 2'b00) m_b++;
        check("status", status, {m_aw[7:0], m_w[7:0], m_s[7:0], m_b[7:0]});
        if (hold_start) begin
            repeat (10) @(negedge clk);
            check("no_retrigger_held", bus.m_axi_awvalid, 0);
            ap_start = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awvalid"}, bus.m_axi_awvalid, 0);
        check({tag, "_wvalid"}, bus.m_axi_wvalid, 0);
        check({tag, "_bready"}, bus.m_axi_bready, 0);
        check({tag, "_tready"}, bus.s_res_tready, 0);
        check({tag, "_ap_done"}, ap_done, 0);
        check({tag, "_ap_ready"}, ap_ready, 0);
        check({tag, "_status"}, status, 0);
        check({tag, "_awaddr"}, bus.m_axi_awaddr, 0);
        check({tag, "_awlen"}, bus.m_axi_awlen, 0);
        check({tag, "_wlast"}, bus.m_axi_wlast, 0);
    endtask

    initial begin
        int unsigned t;
        logic [127:0] d;
        bit ok;
        bus.s_res_tvalid = 1'b0;
        bus.s_res_tdata  = '0;
        #23;
        check_all_zero("rst");
        check("rst_ap_idle", ap_idle, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        run_burst(64'h1000, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        check("basic_status", status, 32'h01040401);

        run_burst({$urandom, $urandom & 32'hFFFF_F000}, 32'd256, 1'b0, 1'b0, 1'b0, 1'b1);
        run_burst({$urandom, $urandom & 32'hFFFF_F000}, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        aw_delay = 20; wready_mode = 1;
        run_burst(64'h0000_0002_0000_0000, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        aw_delay = 0; wready_mode = 0;

        bresp_cfg = 2'b10;
        run_burst(64'h2000, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        bresp_cfg = 2'b00;

        run_burst(64'h3000, 32'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        run_burst(64'h4000, 32'd6, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (6) begin
            aw_delay    = $urandom_range(0, 5);
            wready_mode = $urandom_range(0, 2);
            bresp_cfg   = 2'($urandom_range(0, 3));
            run_burst({$urandom, $urandom & 32'hFFFF_FFF0},
                      {24'($urandom), 8'($urandom_range(1, 40))}, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        aw_delay = 0; wready_mode = 0; bresp_cfg = 2'b00;

        // Reset in the middle of DATA after two of four beats
        aw_q.push_back('{64'h5000, 8'd3});
        exp_n = 4; w_in_burst = 0; s_in_burst = 0;
        base_addr = 64'h5000; num_beats = 32'd4;
        ap_start = 1'b1; @(posedge clk); #1 ap_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            w_q.push_back('{d, 1'b0});
            send_beat(d, ok);
        end
        t = 0;
        while (w_in_burst < 2 && t < 200) begin @(negedge clk); t++; end
        check("mid_w_two", w_in_burst, 2);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        aw_q.delete(); w_q.delete();
        m_aw = 0; m_w = 0; m_s = 0; m_b = 0; aw_seen = 1'b0;
        ap_start = 1'b1;
        #20;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("start_held_ignored", bus.m_axi_awvalid, 0);
        check("start_held_idle", ap_idle, 0);
        @(posedge clk); #1 ap_start = 1'b0;
        repeat (2) @(posedge clk); #1;
        run_burst(64'h6000, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_status", status, 32'h01040401);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
